fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one `fifo` write port among `NUM_REQ` producer engines, for example per-channel conv/MAC result engines feeding the layer output buffer. It grants one requester at a time for a burst of beats. A burst ends on the requester's `LAST`, on reaching `MAX_BURST` beats, or when the requester drops its request. Grant moves to the next requester with no bubble, and FIFO backpressure (`FIFO_FULL`) stalls the granted requester beat by beat.

---
 rtl/npu_arb_pkg.sv | 15 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 25 ++
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/npu_arb_pkg.sv
// Shared arbitration types for the NPU buffer port arbiters.
// Holds the arbiter state encoding and a width helper for index and count fields.
package npu_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Never returns 0, so a one-entry range still gets a usable 1-bit field.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit found
// by searching cyclically upward from ptr_i.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] index_o
);

    // Walk from the far end back toward ptr so the closest candidate wins.
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                valid_o = 1'b1;
                index_o = IW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one fifo write port among NUM_REQ producers.
// Grants bursts, hands over without a bubble and stalls beat by beat on FIFO_FULL.
module fifo_wr_arbiter
    import npu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                          CLKEXT,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ-1:0]            LAST,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] DATA,
    output logic [NUM_REQ-1:0]            ACK,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [$clog2(NUM_REQ)-1:0]    GNT_ID,
    output logic                          BUSY,
    output logic                          FIFO_WR_EN,
    output logic [DATA_WIDTH-1:0]         FIFO_DATA_IN,
    input  logic                          FIFO_FULL
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = idx_w(MAX_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     g_q, g_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;

    logic              busy;
    logic              acc;
    logic              burst_end;
    logic [IW-1:0]     next_ptr;
    logic [IW-1:0]     pick_ptr;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;

    assign busy      = (state_q == ST_BURST);
    assign acc       = busy & REQ[g_q] & ~FIFO_FULL;
    assign burst_end = busy & ((acc & (LAST[g_q] | (cnt_q == CW'(MAX_BURST - 1)))) | ~REQ[g_q]);
    assign next_ptr  = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);

    // One picker serves both the idle pick and the end-of-burst re-arbitration.
    assign pick_ptr = busy ? next_ptr : ptr_q;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req_i   (REQ),
        .ptr_i   (pick_ptr),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        if (!busy) begin
            if (pick_valid) begin
                state_d = ST_BURST;
                g_d     = pick_idx;
                cnt_d   = '0;
                gnt_d   = NUM_REQ'(1) << pick_idx;
            end
        end else if (burst_end) begin
            ptr_d = next_ptr;
            cnt_d = '0;
            if (pick_valid) begin
                g_d   = pick_idx;
                gnt_d = NUM_REQ'(1) << pick_idx;
            end else begin
                state_d = ST_IDLE;
                g_d     = '0;
                gnt_d   = '0;
            end
        end else if (acc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign GNT          = gnt_q;
    assign GNT_ID       = g_q;
    assign BUSY         = busy;
    assign ACK          = acc ? gnt_q : '0;
    assign FIFO_WR_EN   = acc;
    assign FIFO_DATA_IN = busy ? DATA[int'(g_q) * DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus
// hand-written burst-cap and reset-mid-burst sequences.
module tb_fifo_wr_arbiter;

    logic        CLKEXT;
    logic        RST;
    logic [3:0]  REQ;
    logic [3:0]  LAST;
    logic [31:0] DATA;
    logic [3:0]  ACK;
    logic [3:0]  GNT;
    logic [1:0]  GNT_ID;
    logic        BUSY;
    logic        FIFO_WR_EN;
    logic [7:0]  FIFO_DATA_IN;
    logic        FIFO_FULL;

    int n_checks = 0;
    int n_err    = 0;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (16)
    ) dut (
        .CLKEXT       (CLKEXT),
        .RST          (RST),
        .REQ          (REQ),
        .LAST         (LAST),
        .DATA         (DATA),
        .ACK          (ACK),
        .GNT          (GNT),
        .GNT_ID       (GNT_ID),
        .BUSY         (BUSY),
        .FIFO_WR_EN   (FIFO_WR_EN),
        .FIFO_DATA_IN (FIFO_DATA_IN),
        .FIFO_FULL    (FIFO_FULL)
    );

    initial CLKEXT = 1'b0;
    always #5 CLKEXT = ~CLKEXT;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  last;
        logic        full;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic        wr;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs [25];

    // ACK, GNT_ID and BUSY follow from the expected grant and write flag.
    task automatic check_out(input string name, input logic [3:0] eg,
                             input logic ew, input logic [7:0] ed);
        logic [3:0] ea;
        logic [1:0] eid;
        logic       eb;
        ea  = ew ? eg : 4'b0000;
        eb  = |eg;
        eid = 2'd0;
        for (int i = 0; i < 4; i++) if (eg[i]) eid = 2'(i);
        n_checks++;
        if (GNT !== eg || ACK !== ea || FIFO_WR_EN !== ew || FIFO_DATA_IN !== ed ||
            GNT_ID !== eid || BUSY !== eb) begin
            n_err++;
            $display("FAIL %s: got gnt=%b ack=%b wr=%b dout=%h id=%0d busy=%b, want gnt=%b ack=%b wr=%b dout=%h id=%0d busy=%b",
                     name, GNT, ACK, FIFO_WR_EN, FIFO_DATA_IN, GNT_ID, BUSY,
                     eg, ea, ew, ed, eid, eb);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] last,
                         input logic full, input logic [31:0] data);
        @(negedge CLKEXT);
        REQ       = req;
        LAST      = last;
        FIFO_FULL = full;
        DATA      = data;
        #1;
    endtask

    initial begin
        int b1;
        int b3;
        int eg_idx;
        logic [3:0] rq;
        logic [3:0] lt;
        logic [31:0] dt;
        logic ew;
        logic [7:0] ed;
        logic [3:0] eg;

        // Single requester 2, three beats, then drop.
        vecs[0]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A1_0000, 4'b0000, 1'b0, 8'h00};
        vecs[1]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A1_0000, 4'b0100, 1'b1, 8'hA1};
        vecs[2]  = '{4'b0100, 4'b0000, 1'b0, 32'h00A2_0000, 4'b0100, 1'b1, 8'hA2};
        vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 32'h00A3_0000, 4'b0100, 1'b1, 8'hA3};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0100, 1'b0, 8'h00};
        vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0, 8'h00};
        // Round robin, LAST on every beat; pointer sits at 3 after the burst above.
        vecs[6]  = '{4'b1111, 4'b1111, 1'b0, 32'hD3C2_B1A0, 4'b0000, 1'b0, 8'h00};
        vecs[7]  = '{4'b1111, 4'b1111, 1'b0, 32'hD3C2_B1A0, 4'b1000, 1'b1, 8'hD3};
        vecs[8]  = '{4'b1111, 4'b1111, 1'b0, 32'hD3C2_B1A0, 4'b0001, 1'b1, 8'hA0};
        vecs[9]  = '{4'b1111, 4'b1111, 1'b0, 32'hD3C2_B1A0, 4'b0010, 1'b1, 8'hB1};
        vecs[10] = '{4'b1111, 4'b1111, 1'b0, 32'hD3C2_B1A0, 4'b0100, 1'b1, 8'hC2};
        vecs[11] = '{4'b1111, 4'b1111, 1'b0, 32'hD3C2_B1A0, 4'b1000, 1'b1, 8'hD3};
        vecs[12] = '{4'b1111, 4'b1111, 1'b0, 32'hD3C2_B1A0, 4'b0001, 1'b1, 8'hA0};
        // Backpressure: five FULL cycles in the middle of requester 1's burst.
        vecs[13] = '{4'b0010, 4'b0000, 1'b0, 32'h0000_B100, 4'b0010, 1'b1, 8'hB1};
        vecs[14] = '{4'b0010, 4'b0000, 1'b1, 32'h0000_B200, 4'b0010, 1'b0, 8'hB2};
        vecs[15] = '{4'b0010, 4'b0000, 1'b1, 32'h0000_B200, 4'b0010, 1'b0, 8'hB2};
        vecs[16] = '{4'b0010, 4'b0000, 1'b1, 32'h0000_B200, 4'b0010, 1'b0, 8'hB2};
        vecs[17] = '{4'b0010, 4'b0000, 1'b1, 32'h0000_B200, 4'b0010, 1'b0, 8'hB2};
        vecs[18] = '{4'b0010, 4'b0000, 1'b1, 32'h0000_B200, 4'b0010, 1'b0, 8'hB2};
        vecs[19] = '{4'b0010, 4'b0000, 1'b0, 32'h0000_B200, 4'b0010, 1'b1, 8'hB2};
        vecs[20] = '{4'b0010, 4'b0010, 1'b0, 32'h0000_B300, 4'b0010, 1'b1, 8'hB3};
        // Request drop: requester 1 was re-granted, drops, requester 3 takes over.
        vecs[21] = '{4'b1000, 4'b0000, 1'b0, 32'hE000_B400, 4'b0010, 1'b0, 8'hB4};
        vecs[22] = '{4'b1000, 4'b1000, 1'b0, 32'hE000_0000, 4'b1000, 1'b1, 8'hE0};
        vecs[23] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b1000, 1'b0, 8'h00};
        vecs[24] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 1'b0, 8'h00};

        RST       = 1'b1;
        REQ       = 4'b0;
        LAST      = 4'b0;
        DATA      = 32'h0;
        FIFO_FULL = 1'b0;
        repeat (2) @(negedge CLKEXT);
        #1;
        check_out("reset", 4'b0000, 1'b0, 8'h00);
        @(negedge CLKEXT);
        RST = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].req, vecs[i].last, vecs[i].full, vecs[i].data);
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].wr, vecs[i].dout);
        end

        // Burst cap: requester 1 streams 20 beats, requester 3 has 2 beats waiting.
        b1 = 0;
        b3 = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            rq = {b3 < 2, 1'b0, b1 < 20, 1'b0};
            lt = {b3 == 1, 1'b0, b1 == 19, 1'b0};
            dt = {8'(8'h30 + b3), 8'h00, 8'(8'h10 + b1), 8'h00};
            if (cyc == 0 || cyc == 24)      eg_idx = -1;
            else if (cyc == 17 || cyc == 18) eg_idx = 3;
            else                              eg_idx = 1;
            eg = (eg_idx < 0) ? 4'b0000 : 4'(1 << eg_idx);
            ew = (eg_idx >= 0) && rq[eg_idx];
            ed = (eg_idx < 0) ? 8'h00 : dt[eg_idx*8 +: 8];
            drive(rq, lt, 1'b0, dt);
            check_out($sformatf("cap%0d", cyc), eg, ew, ed);
            if (ew && eg_idx == 1) b1++;
            if (ew && eg_idx == 3) b3++;
        end

        // Reset mid-burst: pointer is at 2, so requester 2 wins before reset.
        drive(4'b1111, 4'b0000, 1'b0, 32'hD3C2_B1A0);
        check_out("pre_rst_idle", 4'b0000, 1'b0, 8'h00);
        drive(4'b1111, 4'b0000, 1'b0, 32'hD3C2_B1A0);
        check_out("pre_rst_burst", 4'b0100, 1'b1, 8'hC2);
        #2;
        RST = 1'b1;
        #1;
        check_out("rst_async", 4'b0000, 1'b0, 8'h00);
        @(negedge CLKEXT);
        RST = 1'b0;
        #1;
        check_out("post_rst_idle", 4'b0000, 1'b0, 8'h00);
        drive(4'b1111, 4'b0000, 1'b0, 32'hD3C2_B1A0);
        check_out("post_rst_req0", 4'b0001, 1'b1, 8'hA0);

        drive(4'b0000, 4'b0000, 1'b0, 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
